// File: rtl/mat_matmul_seq.sv
// mat_matmul_seq: sequences one GEMM job on the matrix engine.
// W is loaded row by row into MatUnit and the X rows are streamed through it.
// Each result row is then written back to the destination cache entry.
// Optional feature macro: MAT_SEQ_ABORT_EN adds an abort input and an aborted flag.
module mat_matmul_seq #(
    parameter int WIDTH           = 16,
    parameter int CACHE_SIZE      = 8,
    parameter int UNIT_LATENCY    = 16,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CACHE_ADDR_SIZE-1:0] w_addr,
    input  logic [CACHE_ADDR_SIZE-1:0] x_addr,
    input  logic [CACHE_ADDR_SIZE-1:0] y_addr,
    input  logic [WIDTH_ADDR_SIZE:0]   num_vec,
`ifdef MAT_SEQ_ABORT_EN
    input  logic                       abort,
    output logic                       aborted,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       cache_rd_en,
    output logic [CACHE_ADDR_SIZE-1:0] cache_rd_addr,
    output logic [WIDTH_ADDR_SIZE-1:0] cache_rd_row,
    output logic                       unit_set_weight,
    output logic [WIDTH_ADDR_SIZE-1:0] unit_set_weight_row,
    output logic                       cache_wr_en,
    output logic [CACHE_ADDR_SIZE-1:0] cache_wr_addr,
    output logic [WIDTH_ADDR_SIZE-1:0] cache_wr_row
);

    localparam int DEPTH = 1 + UNIT_LATENCY;
    localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_ROW = WIDTH_ADDR_SIZE'(WIDTH - 1);
    localparam logic [WIDTH_ADDR_SIZE:0]   MAX_VEC  = (WIDTH_ADDR_SIZE + 1)'(WIDTH);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t                     state;
    logic [CACHE_ADDR_SIZE-1:0] x_lat;
    logic [CACHE_ADDR_SIZE-1:0] y_lat;
    logic [WIDTH_ADDR_SIZE:0]   n_lat;
    logic [DEPTH-1:0]           pipe_valid;
    logic [WIDTH_ADDR_SIZE-1:0] pipe_row [DEPTH];
    logic                       push;
    logic                       last_x;
    logic                       pipe_busy;
    logic                       abort_hit;

    // The tail entry leaves at the coming edge, so only the earlier stages decide whether DRAIN is finished.
    assign pipe_busy = |pipe_valid[DEPTH-2:0];
    assign push      = (state == STREAM) && cache_rd_en;
    assign last_x    = ({1'b0, cache_rd_row} == (n_lat - 1'b1));

`ifdef MAT_SEQ_ABORT_EN
    assign abort_hit = abort && busy;

    // The aborted flag accompanies the done pulse that an abort produces.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) aborted <= 1'b0;
        else        aborted <= abort_hit;
    end
`else
    assign abort_hit = 1'b0;
`endif

    // The tail of the tracking pipe drives the write strobe directly; its row tag becomes the destination row.
    assign cache_wr_en   = pipe_valid[DEPTH-1];
    assign cache_wr_row  = pipe_row[DEPTH-1];
    assign cache_wr_addr = cache_wr_en ? y_lat : '0;

    // Write-tracking pipe: each X read carries its row index until the MatUnit result appears.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || abort_hit) begin
            pipe_valid <= '0;
            for (int i = 0; i < DEPTH; i++) pipe_row[i] <= '0;
        end else begin
            pipe_valid  <= {pipe_valid[DEPTH-2:0], push};
            pipe_row[0] <= push ? cache_rd_row : '0;
            for (int i = 1; i < DEPTH; i++) pipe_row[i] <= pipe_row[i-1];
        end
    end

    // Job FSM: the job parameters are latched on start, then the FSM walks through W load, X stream, drain, done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            x_lat               <= '0;
            y_lat               <= '0;
            n_lat               <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            cache_rd_en         <= 1'b0;
            cache_rd_addr       <= '0;
            cache_rd_row        <= '0;
            unit_set_weight     <= 1'b0;
            unit_set_weight_row <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_lat <= x_addr;
                        y_lat <= y_addr;
                        n_lat <= num_vec;
                        if (num_vec == '0 || num_vec > MAX_VEC) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= LOAD_W;
                            busy          <= 1'b1;
                            cache_rd_en   <= 1'b1;
                            cache_rd_addr <= w_addr;
                            cache_rd_row  <= '0;
                        end
                    end
                end
                LOAD_W: begin
                    unit_set_weight     <= 1'b1;
                    unit_set_weight_row <= cache_rd_row;
                    if (cache_rd_row == LAST_ROW) begin
                        state         <= STREAM;
                        cache_rd_addr <= x_lat;
                        cache_rd_row  <= '0;
                    end else begin
                        cache_rd_row <= cache_rd_row + 1'b1;
                    end
                end
                STREAM: begin
                    unit_set_weight     <= 1'b0;
                    unit_set_weight_row <= '0;
                    if (last_x) begin
                        state         <= DRAIN;
                        cache_rd_en   <= 1'b0;
                        cache_rd_addr <= '0;
                        cache_rd_row  <= '0;
                    end else begin
                        cache_rd_row <= cache_rd_row + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (abort_hit) begin
                state               <= DONE;
                busy                <= 1'b0;
                done                <= 1'b1;
                cache_rd_en         <= 1'b0;
                cache_rd_addr       <= '0;
                cache_rd_row        <= '0;
                unit_set_weight     <= 1'b0;
                unit_set_weight_row <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mat_matmul_seq.sv
// Testbench for mat_matmul_seq, including behavioural MatCache and MatUnit models.
// It compares per-cycle strobe traces against hand-derived timing.
// It compares written Y rows against a software X*W reference.
module tb_mat_matmul_seq;

    localparam int LAT = 16;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] w_addr, x_addr, y_addr;
    logic [4:0] num_vec;
    logic       busy, done;
    logic       cache_rd_en, unit_set_weight, cache_wr_en;
    logic [2:0] cache_rd_addr, cache_wr_addr;
    logic [3:0] cache_rd_row, unit_set_weight_row, cache_wr_row;
`ifdef MAT_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int         n_checks;
    int         n_fail;
    logic       init_req;
    logic [22:0] tr [0:63];

    int mem   [8][16][16];
    int rd_data [16];
    int wts   [16][16];
    int upipe [LAT][16];

    mat_matmul_seq dut (
        .clock(clock), .reset(reset), .start(start),
        .w_addr(w_addr), .x_addr(x_addr), .y_addr(y_addr), .num_vec(num_vec),
`ifdef MAT_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .busy(busy), .done(done),
        .cache_rd_en(cache_rd_en), .cache_rd_addr(cache_rd_addr), .cache_rd_row(cache_rd_row),
        .unit_set_weight(unit_set_weight), .unit_set_weight_row(unit_set_weight_row),
        .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr), .cache_wr_row(cache_wr_row)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int minit(int e, int r, int c);
        return (e * 5 + r * 3 + c * 7 + e * r) % 8;
    endfunction

    // Behavioural cache (1-cycle read) and MatUnit (LAT-cycle result pipeline).
    always @(posedge clock) begin
        int acc;
        if (init_req)
            for (int e = 0; e < 8; e++)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) mem[e][r][c] <= minit(e, r, c);
        if (cache_rd_en)
            for (int j = 0; j < 16; j++) rd_data[j] <= mem[cache_rd_addr][cache_rd_row][j];
        if (unit_set_weight)
            for (int j = 0; j < 16; j++) wts[unit_set_weight_row][j] <= rd_data[j];
        for (int j = 0; j < 16; j++) begin
            acc = 0;
            for (int i = 0; i < 16; i++) acc += rd_data[i] * wts[i][j];
            upipe[0][j] <= acc;
        end
        for (int s = 1; s < LAT; s++)
            for (int j = 0; j < 16; j++) upipe[s][j] <= upipe[s-1][j];
        if (cache_wr_en)
            for (int j = 0; j < 16; j++) mem[cache_wr_addr][cache_wr_row][j] <= upipe[LAT-1][j];
    end

    function automatic logic [22:0] pack_obs();
        return {cache_rd_en, cache_rd_en ? cache_rd_addr : 3'd0, cache_rd_en ? cache_rd_row : 4'd0,
                unit_set_weight, unit_set_weight ? unit_set_weight_row : 4'd0,
                cache_wr_en, cache_wr_en ? cache_wr_addr : 3'd0, cache_wr_en ? cache_wr_row : 4'd0,
                busy, done};
    endfunction

    function automatic logic [22:0] exp_trace(int c, logic [2:0] w, logic [2:0] x, logic [2:0] y, int n, bit rej);
        logic       re, sw, we, bs, dn;
        logic [2:0] ra, wa;
        logic [3:0] rr, swr, wr;
        re = 0; sw = 0; we = 0; ra = 0; wa = 0; rr = 0; swr = 0; wr = 0;
        if (rej) return {21'd0, 1'b0, (c == 1)};
        if (c >= 1 && c <= 16) begin re = 1; ra = w; rr = 4'(c - 1); end
        else if (c >= 17 && c <= 16 + n) begin re = 1; ra = x; rr = 4'(c - 17); end
        if (c >= 2 && c <= 17) begin sw = 1; swr = 4'(c - 2); end
        if (c >= 34 && c <= 33 + n) begin we = 1; wa = y; wr = 4'(c - 34); end
        bs = (c >= 1 && c <= 33 + n);
        dn = (c == 34 + n);
        return {re, ra, rr, sw, swr, we, wa, wr, bs, dn};
    endfunction

    task automatic init_mem();
        @(negedge clock);
        init_req = 1'b1;
        @(negedge clock);
        init_req = 1'b0;
    endtask

    task automatic run_job(input logic [2:0] w, input logic [2:0] x, input logic [2:0] y,
                           input logic [4:0] n, input int len, input int p1, input int p2);
        @(negedge clock);
        w_addr = w; x_addr = x; y_addr = y; num_vec = n; start = 1'b1;
        for (int c = 1; c <= len; c++) begin
            @(negedge clock);
            start = (c == p1) || (c == p2);
            tr[c] = pack_obs();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({busy, done, cache_rd_en, cache_rd_addr, cache_rd_row, unit_set_weight, unit_set_weight_row,
             cache_wr_en, cache_wr_addr, cache_wr_row} !== 23'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", pack_obs());
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (pack_obs() !== 23'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %h, expected 0", pack_obs());
        end
    endtask

    task automatic test_basic();
        int e;
        init_mem();
        run_job(3'd0, 3'd1, 3'd2, 5'd3, 40, -1, -1);
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tr[c] !== exp_trace(c, 3'd0, 3'd1, 3'd2, 3, 0)) begin
                n_fail++;
                $display("[TB] FAIL trace_basic cycle %0d: got %h, expected %h", c, tr[c], exp_trace(c, 3'd0, 3'd1, 3'd2, 3, 0));
            end
        end
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 16; j++) begin
                e = 0;
                for (int i = 0; i < 16; i++) e += minit(1, k, i) * minit(0, i, j);
                n_checks++;
                if (mem[2][k][j] !== e) begin
                    n_fail++;
                    $display("[TB] FAIL y_basic[%0d][%0d]: got %0d, expected %0d", k, j, mem[2][k][j], e);
                end
            end
    endtask

    task automatic test_reject();
        for (int t = 0; t < 2; t++) begin
            run_job(3'd0, 3'd1, 3'd2, (t == 0) ? 5'd0 : 5'd17, 5, -1, -1);
            for (int c = 1; c <= 5; c++) begin
                n_checks++;
                if (tr[c] !== exp_trace(c, 3'd0, 3'd1, 3'd2, 0, 1)) begin
                    n_fail++;
                    $display("[TB] FAIL trace_reject n=%0d cycle %0d: got %h, expected %h",
                             (t == 0) ? 0 : 17, c, tr[c], exp_trace(c, 3'd0, 3'd1, 3'd2, 0, 1));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        run_job(3'd0, 3'd1, 3'd2, 5'd3, 40, 5, 30);
        for (int c = 1; c <= 40; c++) begin
            n_checks++;
            if (tr[c] !== exp_trace(c, 3'd0, 3'd1, 3'd2, 3, 0)) begin
                n_fail++;
                $display("[TB] FAIL trace_start_ignored cycle %0d: got %h, expected %h", c, tr[c], exp_trace(c, 3'd0, 3'd1, 3'd2, 3, 0));
            end
        end
    endtask

    task automatic test_alias();
        int e;
        init_mem();
        run_job(3'd4, 3'd3, 3'd3, 5'd16, 53, -1, -1);
        for (int c = 1; c <= 53; c++) begin
            n_checks++;
            if (tr[c] !== exp_trace(c, 3'd4, 3'd3, 3'd3, 16, 0)) begin
                n_fail++;
                $display("[TB] FAIL trace_alias cycle %0d: got %h, expected %h", c, tr[c], exp_trace(c, 3'd4, 3'd3, 3'd3, 16, 0));
            end
        end
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++) begin
                e = 0;
                for (int i = 0; i < 16; i++) e += minit(3, k, i) * minit(4, i, j);
                n_checks++;
                if (mem[3][k][j] !== e) begin
                    n_fail++;
                    $display("[TB] FAIL y_alias[%0d][%0d]: got %0d, expected %0d", k, j, mem[3][k][j], e);
                end
            end
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clock);
        w_addr = 3'd0; x_addr = 3'd1; y_addr = 3'd2; num_vec = 5'd3; start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (pack_obs() !== 23'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_outputs: got %h, expected 0", pack_obs());
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (cache_wr_en || done || busy || cache_rd_en) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_quiet: got %0d active cycles, expected 0", bad);
        end
        test_basic();
    endtask

`ifdef MAT_SEQ_ABORT_EN
    task automatic test_abort();
        logic [22:0] ex;
        init_mem();
        @(negedge clock);
        w_addr = 3'd0; x_addr = 3'd1; y_addr = 3'd2; num_vec = 5'd4; start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clock);
            start = 1'b0;
            abort = (c == 20);
            if (c <= 20) ex = exp_trace(c, 3'd0, 3'd1, 3'd2, 4, 0);
            else         ex = {21'd0, 1'b0, (c == 21)};
            n_checks++;
            if (pack_obs() !== ex) begin
                n_fail++;
                $display("[TB] FAIL trace_abort cycle %0d: got %h, expected %h", c, pack_obs(), ex);
            end
            n_checks++;
            if (aborted !== (c == 21)) begin
                n_fail++;
                $display("[TB] FAIL aborted_flag cycle %0d: got %b, expected %b", c, aborted, (c == 21));
            end
        end
        abort = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        init_req = 1'b0;
        start    = 1'b0;
        w_addr   = '0;
        x_addr   = '0;
        y_addr   = '0;
        num_vec  = '0;
`ifdef MAT_SEQ_ABORT_EN
        abort    = 1'b0;
`endif
        test_reset();
        test_basic();
        test_reject();
        test_start_ignored();
        test_alias();
        test_reset_mid();
`ifdef MAT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
